// File: rtl/balance_pid_pipe.sv
// balance_pid_pipe
//   Pipelined balance controller. Takes pitch and pitch rate samples, forms
//   the PID balance term, scales it by the soft-start ramp, adds the steering
//   differential and registers left/right wheel speed commands. A sample taken
//   on vld in cycle N appears on the outputs with spd_vld in cycle N+3.
//
//   Optional build macro: BALANCE_ANTIWINDUP_EN. When it is defined, a sample
//   whose PID term saturates does not commit its contribution to the integrator.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   vld               one-cycle strobe for a new pitch sample
//   ptch, ptch_rt     signed pitch and pitch rate
//   pwr_up            controller enable; low clears state and zeroes outputs
//   rider_off         no rider; clears integrator and soft-start timer
//   steer_pot         unsigned steering pot, centre 12'h7FF
//   en_steer          steering enable
//   lft_spd, rght_spd signed wheel speed commands
//   spd_vld           one-cycle strobe when the speeds update
//   too_fast          either speed above TOO_FAST_LIM
module balance_pid_pipe #(
  parameter int PTCH_W       = 16,
  parameter int SPD_W        = 12,
  parameter int P_COEFF      = 8,
  parameter int I_SHIFT      = 6,
  parameter int D_SHIFT      = 2,
  parameter int SS_PRESC     = 2,
  parameter int TOO_FAST_LIM = 1536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [PTCH_W-1:0] ptch_rt,
  input  logic                     pwr_up,
  input  logic                     rider_off,
  input  logic [11:0]              steer_pot,
  input  logic                     en_steer,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     spd_vld,
  output logic                     too_fast
);

  localparam int PRESC_W = (SS_PRESC > 1) ? $clog2(SS_PRESC) : 1;
  localparam int SW2     = SPD_W + 2;
  localparam int PROD_W  = SPD_W + 9;

  localparam logic [PRESC_W-1:0]       PRESC_LAST = PRESC_W'(SS_PRESC - 1);
  localparam logic signed [PTCH_W-1:0] PERR_MAX   = PTCH_W'(511);
  localparam logic signed [PTCH_W-1:0] PERR_MIN   = PTCH_W'(-512);
  localparam logic signed [PTCH_W-1:0] RT_MAX     = PTCH_W'(4095);
  localparam logic signed [PTCH_W-1:0] RT_MIN     = PTCH_W'(-4096);
  localparam logic signed [18:0]       INTEG_MAX  = 19'sd131071;
  localparam logic signed [18:0]       INTEG_MIN  = ~INTEG_MAX;
  localparam logic signed [19:0]       PID_MAX    = 20'((1 << (SPD_W - 1)) - 1);
  localparam logic signed [19:0]       PID_MIN    = ~PID_MAX;
  localparam logic signed [19:0]       P_GAIN     = 20'(P_COEFF);
  localparam logic signed [SW2-1:0]    SPD_MAX    = SW2'((1 << (SPD_W - 1)) - 1);
  localparam logic signed [SW2-1:0]    SPD_MIN    = ~SPD_MAX;
  localparam logic signed [SPD_W-1:0]  TF_LIM     = SPD_W'(TOO_FAST_LIM);
  localparam logic signed [12:0]       STEER_CTR  = 13'sh07FF;

  function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [SW2-1:0] x);
    if (x > SPD_MAX)      sat_spd = SPD_MAX[SPD_W-1:0];
    else if (x < SPD_MIN) sat_spd = SPD_MIN[SPD_W-1:0];
    else                  sat_spd = x[SPD_W-1:0];
  endfunction

  // ---------------- stage 1: input saturation and integrator ----------------
  logic signed [17:0] integ;
  logic signed [9:0]  perr_c, perr_s1;
  logic signed [12:0] rt_c, rt_s1;
  logic signed [18:0] isum;
  logic signed [17:0] integ_c, integ_s1;
  logic               integ_commit;
  logic               v1;

  always_comb begin
    if (ptch > PERR_MAX)      perr_c = 10'h1FF;
    else if (ptch < PERR_MIN) perr_c = 10'h200;
    else                      perr_c = ptch[9:0];
    if (ptch_rt > RT_MAX)      rt_c = 13'h0FFF;
    else if (ptch_rt < RT_MIN) rt_c = 13'h1000;
    else                       rt_c = ptch_rt[12:0];
    isum = 19'(integ) + 19'(perr_c);
    if (isum > INTEG_MAX)      integ_c = 18'h1FFFF;
    else if (isum < INTEG_MIN) integ_c = 18'h20000;
    else                       integ_c = isum[17:0];
  end

`ifdef BALANCE_ANTIWINDUP_EN
  // Evaluate the stage-2 sum with the candidate integrator now, so the commit
  // decision is made in the same cycle the integrator would update. Stage 2
  // still sees the candidate value, so the speeds match the plain build.
  logic signed [19:0] pid_try;
  always_comb begin
    pid_try      = 20'(perr_c) * P_GAIN + 20'(integ_c >>> I_SHIFT) + 20'(rt_c >>> D_SHIFT);
    integ_commit = (pid_try <= PID_MAX) && (pid_try >= PID_MIN);
  end
`else
  assign integ_commit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ    <= '0;
      perr_s1  <= '0;
      rt_s1    <= '0;
      integ_s1 <= '0;
      v1       <= 1'b0;
    end else if (!pwr_up) begin
      integ <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= vld;
      if (vld) begin
        perr_s1  <= perr_c;
        rt_s1    <= rt_c;
        integ_s1 <= rider_off ? 18'sd0 : integ_c;
      end
      if (rider_off)                integ <= '0;
      else if (vld && integ_commit) integ <= integ_c;
    end
  end

  // ---------------- soft-start timer ----------------
  logic [PRESC_W-1:0] presc;
  logic [7:0]         ss_tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      ss_tmr <= '0;
    end else if (!pwr_up) begin
      presc  <= '0;
      ss_tmr <= '0;
    end else if (rider_off) begin
      ss_tmr <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      if (ss_tmr != 8'hFF) ss_tmr <= ss_tmr + 8'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------- stage 2: PID sum and soft-start scaling ----------------
  logic signed [19:0]       pid_c;
  logic signed [SPD_W-1:0]  pid_sat, pidss_c, pidss_s2;
  logic signed [PROD_W-1:0] pid_prod;
  logic                     v2;

  always_comb begin
    pid_c = 20'(perr_s1) * P_GAIN + 20'(integ_s1 >>> I_SHIFT) + 20'(rt_s1 >>> D_SHIFT);
    if (pid_c > PID_MAX)      pid_sat = PID_MAX[SPD_W-1:0];
    else if (pid_c < PID_MIN) pid_sat = PID_MIN[SPD_W-1:0];
    else                      pid_sat = pid_c[SPD_W-1:0];
    pid_prod = PROD_W'(pid_sat) * PROD_W'($signed({1'b0, ss_tmr}));
    pidss_c  = (ss_tmr == 8'hFF) ? pid_sat : SPD_W'(pid_prod >>> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pidss_s2 <= '0;
      v2       <= 1'b0;
    end else if (!pwr_up) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) pidss_s2 <= pidss_c;
    end
  end

  // ---------------- stage 3: steering and output registers ----------------
  logic signed [12:0]      steer_c;
  logic signed [SPD_W-1:0] lft_c, rght_c;

  always_comb begin
    steer_c = en_steer ? (($signed({1'b0, steer_pot}) - STEER_CTR) >>> 3) : 13'sd0;
    lft_c   = sat_spd(SW2'(pidss_s2) + SW2'(steer_c));
    rght_c  = sat_spd(SW2'(pidss_s2) - SW2'(steer_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
      too_fast <= 1'b0;
    end else if (!pwr_up) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
      too_fast <= 1'b0;
    end else begin
      spd_vld <= v2;
      if (v2) begin
        lft_spd  <= lft_c;
        rght_spd <= rght_c;
        too_fast <= (lft_c > TF_LIM) || (rght_c > TF_LIM);
      end
    end
  end

endmodule

// File: doc/balance_pid_pipe.md
# balance_pid_pipe

Parametrised, pipelined successor to the team's balance controller: a single block that computes the PID balance term from pitch and pitch rate, applies the soft-start ramp and steering, and drives left/right wheel speed commands. The integrator, soft-start timer and speed math all live in one registered datapath with a defined latency and an output strobe. It sits between the inertial interface, which supplies `vld`, `ptch` and `ptch_rt`, and the motor drive, which consumes `lft_spd` and `rght_spd`.

## Interface
- `PTCH_W`, default 16: width of `ptch` and `ptch_rt`.
- `SPD_W`, default 12: width of the signed speed outputs.
- `P_COEFF`, default 8: proportional multiplier.
- `I_SHIFT`, default 6: integrator right-shift.
- `D_SHIFT`, default 2: pitch-rate right-shift.
- `SS_PRESC`, default 2: clocks per soft-start step. Use small values for simulation and large values for silicon.
- `TOO_FAST_LIM`, default 1536: signed speed threshold for `too_fast`.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `vld` in 1: new pitch sample strobe, one cycle.
- `ptch` in `PTCH_W`: signed pitch.
- `ptch_rt` in `PTCH_W`: signed pitch rate.
- `pwr_up` in 1: enables the controller.
- `rider_off` in 1: no rider present.
- `steer_pot` in 12: unsigned steering pot, centre is 12'h7FF.
- `en_steer` in 1: enables steering.
- `lft_spd` out `SPD_W`: signed left speed.
- `rght_spd` out `SPD_W`: signed right speed.
- `spd_vld` out 1: one-cycle strobe when the speeds update.
- `too_fast` out 1: either speed is above `TOO_FAST_LIM`.

## Operation
- Reset values: `lft_spd`=0, `rght_spd`=0, `spd_vld`=0, `too_fast`=0; integrator=0; `ss_tmr`=0; prescaler=0.
- Stage 1 (on `vld`):
  - `ptch` is saturated to signed 10 bits (range -512..511), giving `perr`.
  - `ptch_rt` is saturated to signed 13 bits.
  - Integrator is 18-bit signed. On `vld` and not `rider_off`, it becomes integ+sext(`perr`), saturating at ±2^17.
- Stage 2: `PID` = `perr`*`P_COEFF` + (integ>>>`I_SHIFT`) + (`ptch_rt`>>>`D_SHIFT`).
  - Compute at 20 bits signed, then saturate to `SPD_W` signed.
  - The integrator value used is the one updated in stage 1 for the same sample.
- Soft start:
  - `ss_tmr` is 8 bits. It increments once every `SS_PRESC` clocks while `pwr_up` is high and `rider_off` is low.
  - It holds at 255.
  - Output is `PID`*`ss_tmr`>>>8 while `ss_tmr`<255, and unscaled `PID` at 255.
- Stage 3, steering:
  - `steer` = (`steer_pot` − 12'h7FF) >>> 3 when `en_steer` is high, else 0.
  - `lft` = `PIDss` + `steer` and `rght` = `PIDss` − `steer`, each saturated to `SPD_W`.
  - `too_fast` = (`lft`>`TOO_FAST_LIM`) | (`rght`>`TOO_FAST_LIM`), registered with the speeds.
- `rider_off` high: integrator clears and `ss_tmr` clears on the next clock. Pipeline samples still flow, so speeds ramp back down through soft start.
- `pwr_up` low: integrator, `ss_tmr` and prescaler clear. Outputs are forced to 0, `too_fast`=0, and `spd_vld` is suppressed.

## Timing
- Latency: `vld` in cycle N gives updated `lft_spd`/`rght_spd`/`too_fast` and `spd_vld`=1 in cycle N+3.
- Outputs hold between strobes.
- `vld` on consecutive cycles is legal. Each sample produces its own strobe three cycles later, so throughput is one per clock.
- `rider_off` rising in the same cycle as `vld`: the integrator does not accumulate; it clears.
- `pwr_up` falling mid-pipeline: in-flight samples are discarded, and outputs read 0 from the next clock.
- Async reset mid-operation: all state returns to reset values immediately. The first strobe after release needs a fresh `vld`.
- `steer_pot` and `en_steer` are sampled at stage 3, not at `vld`.

## Configuration
- `BALANCE_ANTIWINDUP_EN` defined: the integrator does not update on a sample whose stage-2 `PID` saturated. Speeds are otherwise unchanged.
- `BALANCE_ANTIWINDUP_EN` undefined: the integrator freezes only at its own ±2^17 limit.

## Test plan
- Basic PID path:
  - Stimulus: `pwr_up`=1 for 600 clocks (`ss_tmr`=255), `rider_off`=0, `en_steer`=0; one `vld` with `ptch`=16, `ptch_rt`=0.
  - Response: `spd_vld` 3 cycles later; `lft_spd`=`rght_spd`=128; `too_fast`=0.
- Steering: same setup with `en_steer`=1 and `steer_pot`=12'h8FF → `lft_spd`=160, `rght_spd`=96.
- Saturation: `ptch`=16'h7FFF → both speeds 2047, `too_fast`=1. `ptch`=16'h8000 → both −2048, `too_fast`=0.
- Soft start: `vld` with `ptch`=16 when `ss_tmr`=128 → both speeds 64.
- Rider off: assert `rider_off` after 100 `vld`s with `ptch`=64.
  - Integrator reads 0 next clock.
  - Next `vld` with `ptch`=16 gives speeds 0, since `ss_tmr`=0.
- Power-down and reset:
  - Drop `pwr_up` between `vld` and strobe → no strobe, outputs 0.
  - Assert `rst_n`=0 mid-pipeline → all outputs 0 asynchronously.
  - Run both cases with and without `BALANCE_ANTIWINDUP_EN`.
